// File: rtl/ps2_kbd_io.sv
// ps2_kbd_io: PS/2 keyboard receiver with scan-code FIFO; optional break filter via PS2_BREAK_FILTER_EN
module ps2_kbd_io #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        io_rdn,
  output logic [31:0] io_data,
  output logic        kbd_ready
);
`ifdef PS2_BREAK_FILTER_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t          state;
  logic [2:0]      kc_s, kd_s;
  logic [TW-1:0]   cnt;
  logic [2:0]      bcnt;
  logic [7:0]      sr;
  logic            par, err, ovf, push_v, pend;
  logic [EW-1:0]   push_b, head;
  logic [EW-1:0]   mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic            fall, bit_in, empty, full, pop, push_ok;
  assign fall    = kc_s[2:1] == 2'b10;
  assign bit_in  = kd_s[1];
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) && (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop     = !io_rdn && !empty;
  assign push_ok = push_v && (!full || pop);
  // three-flop synchronisers for the asynchronous PS/2 lines
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      kc_s <= '1;
      kd_s <= '1;
    end else begin
      kc_s <= {kc_s[1:0], ps2_clk};
      kd_s <= {kd_s[1:0], ps2_data};
    end
  // frame FSM: one step per ps2_clk falling edge, aborts stalled frames, owns the error sticky
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state  <= IDLE;
      cnt    <= '0;
      bcnt   <= '0;
      sr     <= '0;
      par    <= 1'b0;
      err    <= 1'b0;
      push_v <= 1'b0;
      push_b <= '0;
      pend   <= 1'b0;
    end else begin
      push_v <= 1'b0;
      if (!io_rdn) err <= 1'b0;
      cnt <= (fall || state == IDLE) ? '0 : cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: if (!bit_in) begin
            state <= DATA;
            bcnt  <= '0;
          end
          DATA: begin
            sr    <= {bit_in, sr[7:1]};
            bcnt  <= bcnt + 1'b1;
            state <= bcnt == 3'd7 ? PARITY : DATA;
          end
          PARITY: begin
            par   <= bit_in;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (bit_in && ^{sr, par}) begin
`ifdef PS2_BREAK_FILTER_EN
              if (sr == 8'hF0) pend <= 1'b1;
              else begin
                push_v <= 1'b1;
                push_b <= {pend, sr};
                pend   <= 1'b0;
              end
`else
              push_v <= 1'b1;
              push_b <= sr;
`endif
            end else begin
              err  <= 1'b1;
              pend <= 1'b0;
            end
          end
        endcase
      end else if (state != IDLE && cnt == TW'(TIMEOUT - 1)) begin
        state <= IDLE;
        err   <= 1'b1;
        pend  <= 1'b0;
      end
    end
  // FIFO storage; a full FIFO may still accept a write when the head is popped in the same cycle
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= push_b;
  // FIFO pointers and overflow sticky; a new overflow beats a same-cycle clear
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      ovf <= (push_v && full && !pop) || (ovf && io_rdn);
    end
  // combinational status+data word so a single-cycle lw sees it immediately
  always_comb begin
    head = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
`ifdef PS2_BREAK_FILTER_EN
    io_data = {20'h0, head[8], err, ovf, !empty, head[7:0]};
`else
    io_data = {20'h0, 1'b0, err, ovf, !empty, head[7:0]};
`endif
    kbd_ready = !empty;
  end
endmodule

// File: tb/tb_ps2_kbd_io.sv
// tb_ps2_kbd_io: directed scoreboard bench for ps2_kbd_io
module tb_ps2_kbd_io;
  localparam int AW = 3, TO = 300, HP = 8;
  logic clk = 0, clrn = 0, ps2_clk = 1, ps2_data = 1, io_rdn = 1;
  logic [31:0] io_data;
  logic kbd_ready;
  int tests = 0, fails = 0;
  logic [8:0] q[$];
  bit ovf_m = 0, err_m = 0, pend_m = 0;
  always #5 clk = ~clk;
  ps2_kbd_io #(.FIFO_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .io_rdn(io_rdn), .io_data(io_data), .kbd_ready(kbd_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_word();
    logic [8:0] h;
    h = q.size() != 0 ? q[0] : 9'h0;
    return {20'h0, h[8], err_m, ovf_m, q.size() != 0, h[7:0]};
  endfunction
  task automatic status(input string tag);
    @(negedge clk);
    chk(tag, io_data, exp_word());
    chk({tag, "_rdy"}, {31'b0, kbd_ready}, {31'b0, q.size() != 0});
  endtask
  task automatic rd(input string tag, input int n);
    @(negedge clk);
    io_rdn = 0;
    for (int i = 0; i < n; i++) begin
      #1 chk(tag, io_data, exp_word());
      if (q.size() != 0) void'(q.pop_front());
      ovf_m = 0;
      err_m = 0;
      @(negedge clk);
    end
    io_rdn = 1;
  endtask
  task automatic bits(input logic b);
    ps2_data = b;
    repeat (HP) @(negedge clk);
    ps2_clk = 0;
    repeat (HP) @(negedge clk);
    ps2_clk = 1;
  endtask
  task automatic put(input logic [8:0] e);
    if (q.size() < 2**AW) q.push_back(e);
    else ovf_m = 1;
  endtask
  task automatic frame(input logic [7:0] d, input bit bad);
    bits(1'b0);
    for (int i = 0; i < 8; i++) bits(d[i]);
    bits(~^d ^ bad);
    bits(1'b1);
    repeat (HP) @(negedge clk);
    if (bad) begin
      err_m = 1;
      pend_m = 0;
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (d == 8'hF0) pend_m = 1;
      else begin
        put({pend_m, d});
        pend_m = 0;
      end
`else
      put({1'b0, d});
`endif
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data", io_data, 32'h0);
    chk("reset_rdy", {31'b0, kbd_ready}, 32'h0);
    clrn = 1;
    repeat (3) @(negedge clk);
    frame(8'h1C, 0);
    status("one");
    chk("one_lit", io_data, 32'h0000011C);
    rd("one_rd", 1);
    status("one_after");
    frame(8'h1C, 0);
    frame(8'h32, 0);
    frame(8'h21, 0);
    rd("b2b", 2);
    status("b2b_rem");
    rd("b2b_drain", 1);
    for (int i = 0; i < 9; i++) frame(8'h10 + 8'(i), 0);
    status("full");
    rd("ovf_rd", 1);
    rd("ovf_clr", 1);
    rd("drain", 6);
    status("drained");
    frame(8'h1C, 1);
    status("par");
    rd("par_rd", 1);
    status("par_clr");
    bits(1'b0);
    for (int i = 0; i < 4; i++) bits(1'b1);
    repeat (TO + 20) @(negedge clk);
    err_m = 1;
    frame(8'h1C, 0);
    status("to");
    rd("to_rd", 1);
    status("to_empty");
    frame(8'hF0, 0);
    frame(8'h1C, 0);
    status("brk");
    rd("brk_rd", q.size());
    status("brk_empty");
    bits(1'b1);
    repeat (HP) @(negedge clk);
    status("glitch");
    bits(1'b0);
    bits(1'b1);
    bits(1'b0);
    clrn = 0;
    repeat (2) @(negedge clk);
    q.delete();
    ovf_m = 0;
    err_m = 0;
    pend_m = 0;
    status("midreset");
    clrn = 1;
    repeat (3) @(negedge clk);
    frame(8'h5A, 0);
    status("post_reset");
    rd("post_rd", 1);
    status("post_empty");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
